// File: rtl/glitch_sequencer_if.sv
// Control and status bundle for glitch_sequencer.
// The arm_i/trig_i pair exists only when GLITCH_EXT_TRIG_EN is defined.
interface glitch_sequencer_if;
    logic        start_i;
    logic        abort_i;
    logic [15:0] delay_i;
    logic [7:0]  width_i;
    logic [7:0]  num_pulses_i;
    logic [15:0] spacing_i;
    logic        glitch_o;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  pulse_cnt_o;
`ifdef GLITCH_EXT_TRIG_EN
    logic        arm_i;
    logic        trig_i;
`endif

    modport master (
        output start_i, abort_i, delay_i, width_i, num_pulses_i, spacing_i,
`ifdef GLITCH_EXT_TRIG_EN
        output arm_i, trig_i,
`endif
        input  glitch_o, busy_o, done_o, pulse_cnt_o
    );

    modport slave (
        input  start_i, abort_i, delay_i, width_i, num_pulses_i, spacing_i,
`ifdef GLITCH_EXT_TRIG_EN
        input  arm_i, trig_i,
`endif
        output glitch_o, busy_o, done_o, pulse_cnt_o
    );
endinterface

// File: rtl/glitch_sequencer.sv
// Programmable glitch pulse-train generator: delay, then num pulses of width cycles separated by spacing.
// Define GLITCH_EXT_TRIG_EN to add the ARMED state with an arm_i strobe and a synchronized trig_i start.
module glitch_sequencer #(
    parameter bit GLITCH_ACTIVE_HIGH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    glitch_sequencer_if.slave bus
);
    localparam logic IDLE_LVL = ~GLITCH_ACTIVE_HIGH;

`ifdef GLITCH_EXT_TRIG_EN
    typedef enum logic [2:0] {IDLE, ARMED, DELAY, PULSE, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DELAY, PULSE, GAP} state_t;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [7:0]  r_width;
    logic [7:0]  r_num;
    logic [15:0] r_spacing;
    logic [7:0]  r_pulse_cnt;
    logic [7:0]  w_pulse_cnt_nxt;
    logic        r_glitch;
    logic        r_busy;
    logic        w_busy_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        w_glitch_on;
    logic        w_capture;
    logic [15:0] w_width_m1;
    logic [15:0] w_gap_m1;

`ifdef GLITCH_EXT_TRIG_EN
    logic r_trig_s1;
    logic r_trig_s2;
    logic r_trig_s3;
    logic w_trig_rise;

    // Two flops for metastability, the third only delays for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig_s1 <= 1'b0;
            r_trig_s2 <= 1'b0;
            r_trig_s3 <= 1'b0;
        end else begin
            r_trig_s1 <= bus.trig_i;
            r_trig_s2 <= r_trig_s1;
            r_trig_s3 <= r_trig_s2;
        end
    end

    assign w_trig_rise = r_trig_s2 & ~r_trig_s3;
`endif

    assign w_width_m1 = {8'd0, r_width} - 16'd1;
    assign w_gap_m1   = (r_spacing == 16'd0) ? 16'd0 : r_spacing - 16'd1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // The delay down-counter is loaded straight from delay_i and doubles as its shadow copy.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_pulse_cnt_nxt = r_pulse_cnt;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_glitch_on     = 1'b0;
        w_capture       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start_i) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = bus.delay_i;
                    w_state_nxt = DELAY;
                end
`ifdef GLITCH_EXT_TRIG_EN
                else if (bus.arm_i) begin
                    w_state_nxt = ARMED;
                end
`endif
            end
`ifdef GLITCH_EXT_TRIG_EN
            ARMED: begin
                if (bus.start_i || w_trig_rise) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = bus.delay_i;
                    w_state_nxt = DELAY;
                end
            end
`endif
            DELAY: begin
                w_busy_nxt = 1'b1;
                if (r_cnt != 16'd0) begin
                    w_cnt_nxt       = r_cnt - 16'd1;
                    w_pulse_cnt_nxt = 8'd0;
                end else if (r_num == 8'd0 || r_width == 8'd0) begin
                    w_done_nxt      = 1'b1;
                    w_busy_nxt      = 1'b0;
                    w_pulse_cnt_nxt = 8'd0;
                    w_state_nxt     = IDLE;
                end else begin
                    w_glitch_on     = 1'b1;
                    w_cnt_nxt       = w_width_m1;
                    w_pulse_cnt_nxt = 8'd1;
                    w_state_nxt     = PULSE;
                end
            end
            PULSE: begin
                if (r_cnt != 16'd0) begin
                    w_glitch_on = 1'b1;
                    w_cnt_nxt   = r_cnt - 16'd1;
                end else if (r_pulse_cnt == r_num) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt   = w_gap_m1;
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                if (r_cnt != 16'd0) begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end else begin
                    w_glitch_on     = 1'b1;
                    w_cnt_nxt       = w_width_m1;
                    w_pulse_cnt_nxt = r_pulse_cnt + 8'd1;
                    w_state_nxt     = PULSE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (bus.abort_i) begin
            w_state_nxt     = IDLE;
            w_cnt_nxt       = r_cnt;
            w_pulse_cnt_nxt = r_pulse_cnt;
            w_busy_nxt      = 1'b0;
            w_done_nxt      = 1'b0;
            w_glitch_on     = 1'b0;
            w_capture       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 16'd0;
            r_width     <= 8'd0;
            r_num       <= 8'd0;
            r_spacing   <= 16'd0;
            r_pulse_cnt <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_glitch    <= IDLE_LVL;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_pulse_cnt <= w_pulse_cnt_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_glitch    <= w_glitch_on ? ~IDLE_LVL : IDLE_LVL;
            if (w_capture) begin
                r_width   <= bus.width_i;
                r_num     <= bus.num_pulses_i;
                r_spacing <= bus.spacing_i;
            end
        end
    end

    assign bus.glitch_o    = r_glitch;
    assign bus.busy_o      = r_busy;
    assign bus.done_o      = r_done;
    assign bus.pulse_cnt_o = r_pulse_cnt;
endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed, table-driven bench for glitch_sequencer (active-high glitch polarity).
// Cycle numbers are counted in rising edges after the edge T0 that samples start_i.
module tb_glitch_sequencer;
    logic clk;
    logic rst;
    int   passCount;
    int   checkCount;

    glitch_sequencer_if bus ();

    glitch_sequencer #(.GLITCH_ACTIVE_HIGH(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] delay;
        logic [7:0]  width;
        logic [7:0]  num;
        logic [15:0] spacing;
        int          expFirst;
        int          expHighs;
        int          expDone;
        logic [31:0] expMask;
        int          expCnt1;
        int          expCnt;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic setParams(input logic [15:0] d, input logic [7:0] w, input logic [7:0] n,
                             input logic [15:0] s);
        bus.delay_i      = d;
        bus.width_i      = w;
        bus.num_pulses_i = n;
        bus.spacing_i    = s;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input bit midChange, input int idx);
        int          first;
        int          highs;
        int          doneAt;
        int          doneCnt;
        int          busyCnt;
        int          cnt1;
        logic [31:0] mask;
        first   = -1;
        highs   = 0;
        doneAt  = -1;
        doneCnt = 0;
        busyCnt = 0;
        cnt1    = -1;
        mask    = '0;
        @(negedge clk);
        setParams(v.delay, v.width, v.num, v.spacing);
        pulseStart();
        for (int k = 1; k <= v.expDone + 4; k++) begin
            @(posedge clk);
            #1;
            if (midChange && k == 1) setParams(16'd100, 8'd9, 8'd7, 16'd50);
            if (bus.glitch_o) begin
                highs++;
                if (first < 0) first = k;
                if (k < 32) mask[k] = 1'b1;
            end
            if (bus.busy_o) busyCnt++;
            if (bus.done_o) begin
                doneCnt++;
                if (doneAt < 0) doneAt = k;
            end
            if (k == 1) cnt1 = int'(bus.pulse_cnt_o);
        end
        checkOutput($sformatf("v%0d first", idx), first, v.expFirst);
        checkOutput($sformatf("v%0d highs", idx), highs, v.expHighs);
        checkOutput($sformatf("v%0d mask", idx), int'(mask), int'(v.expMask));
        checkOutput($sformatf("v%0d doneAt", idx), doneAt, v.expDone);
        checkOutput($sformatf("v%0d doneCnt", idx), doneCnt, 1);
        checkOutput($sformatf("v%0d busyCnt", idx), busyCnt, v.expDone - 1);
        checkOutput($sformatf("v%0d cntT1", idx), cnt1, v.expCnt1);
        checkOutput($sformatf("v%0d cntEnd", idx), int'(bus.pulse_cnt_o), v.expCnt);
    endtask

    initial begin
        int   doneCnt;
        int   highs;
        int   busySeen;
        passCount        = 0;
        checkCount       = 0;
        rst              = 1'b1;
        bus.start_i      = 1'b0;
        bus.abort_i      = 1'b0;
        setParams(16'd0, 8'd0, 8'd0, 16'd0);
`ifdef GLITCH_EXT_TRIG_EN
        bus.arm_i        = 1'b0;
        bus.trig_i       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst glitch", int'(bus.glitch_o), 0);
        checkOutput("rst busy", int'(bus.busy_o), 0);
        checkOutput("rst done", int'(bus.done_o), 0);
        checkOutput("rst cnt", int'(bus.pulse_cnt_o), 0);

        // delay, width, num, spacing | first, highs, done, mask, cnt@T0+1, cnt@end
        vecs[0] = '{16'd3, 8'd2, 8'd3, 16'd4, 4, 6, 18, 32'h0003_0C30, 0, 3};
        vecs[1] = '{16'd0, 8'd1, 8'd1, 16'd0, 1, 1, 2, 32'h0000_0002, 1, 1};
        vecs[2] = '{16'd5, 8'd3, 8'd0, 16'd2, -1, 0, 6, 32'h0, 0, 0};
        vecs[3] = '{16'd2, 8'd0, 8'd4, 16'd1, -1, 0, 3, 32'h0, 0, 0};
        vecs[4] = '{16'd1, 8'd1, 8'd3, 16'd0, 2, 3, 7, 32'h0000_0054, 0, 3};
        vecs[5] = '{16'd0, 8'd4, 8'd2, 16'd2, 1, 8, 11, 32'h0000_079E, 1, 2};
        vecs[6] = '{16'd65535, 8'd1, 8'd1, 16'd7, 65536, 1, 65537, 32'h0, 0, 1};
        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], 1'b0, i);

        applyStimulus('{16'd3, 8'd1, 8'd2, 16'd2, 4, 2, 8, 32'h0000_0090, 0, 2}, 1'b1, 7);

        // Abort during the 5th asserted cycle of pulse 1, with a stray start earlier.
        @(negedge clk);
        setParams(16'd1, 8'd10, 8'd2, 16'd3);
        pulseStart();
        doneCnt = 0;
        highs   = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.glitch_o) highs++;
            if (bus.done_o) doneCnt++;
            if (k == 4) checkOutput("abort cnt midrun", int'(bus.pulse_cnt_o), 1);
            if (k == 5) checkOutput("abort busy before", int'(bus.busy_o), 1);
            if (k == 6) checkOutput("abort glitch before", int'(bus.glitch_o), 1);
            if (k == 7) begin
                checkOutput("abort glitch after", int'(bus.glitch_o), 0);
                checkOutput("abort busy after", int'(bus.busy_o), 0);
                checkOutput("abort cnt hold", int'(bus.pulse_cnt_o), 1);
            end
            bus.start_i = (k == 2);
            bus.abort_i = (k == 6);
        end
        checkOutput("abort done", doneCnt, 0);
        checkOutput("abort highs", highs, 5);

        // Abort and start together in IDLE: the abort wins.
        @(negedge clk);
        setParams(16'd0, 8'd1, 8'd1, 16'd0);
        bus.abort_i = 1'b1;
        pulseStart();
        bus.abort_i = 1'b0;
        busySeen = 0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy_o || bus.glitch_o) busySeen++;
        end
        checkOutput("abort prio", busySeen, 0);

        // Reset in the middle of a pulse.
        @(negedge clk);
        setParams(16'd0, 8'd10, 8'd1, 16'd0);
        pulseStart();
        doneCnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) doneCnt++;
            if (k == 3) checkOutput("rstmid glitch before", int'(bus.glitch_o), 1);
            if (k == 4) begin
                checkOutput("rstmid glitch after", int'(bus.glitch_o), 0);
                checkOutput("rstmid busy", int'(bus.busy_o), 0);
                checkOutput("rstmid cnt", int'(bus.pulse_cnt_o), 0);
            end
            rst = (k == 3);
        end
        checkOutput("rstmid done", doneCnt, 0);

`ifdef GLITCH_EXT_TRIG_EN
        // Trigger edge while not armed is ignored.
        @(negedge clk);
        setParams(16'd2, 8'd1, 8'd1, 16'd0);
        bus.trig_i = 1'b1;
        busySeen = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy_o) busySeen++;
        end
        checkOutput("trig unarmed", busySeen, 0);
        bus.trig_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.arm_i = 1'b1;
        @(posedge clk);
        #1;
        bus.arm_i  = 1'b0;
        bus.trig_i = 1'b1;
        highs   = -1;
        doneCnt = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.glitch_o && highs < 0) highs = k;
            if (bus.done_o && doneCnt < 0) doneCnt = k;
        end
        bus.trig_i = 1'b0;
        checkOutput("trig first glitch", highs, 6);
        checkOutput("trig done", doneCnt, 7);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/glitch_sequencer.md
GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

Interface
REQ-001 SHALL have parameter GLITCH_ACTIVE_HIGH, default 1; glitch_o polarity: 1 = asserted high, 0 = asserted low (idle level inverted).
REQ-002 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is rst, synchronous, active-high; clock is clk.
REQ-004 SHALL have port start_i, input, 1, one-cycle software start strobe.
REQ-005 SHALL have port abort_i, input, 1, level; terminates any run.
REQ-006 SHALL have port delay_i, input, 16, idle cycles from start to first pulse.
REQ-007 SHALL have port width_i, input, 8, asserted cycles per pulse.
REQ-008 SHALL have port num_pulses_i, input, 8, pulses per run.
REQ-009 SHALL have port spacing_i, input, 16, deasserted cycles between pulses.
REQ-010 SHALL have port glitch_o, output, 1, registered glitch drive.
REQ-011 SHALL have port busy_o, output, 1, high while a run is in progress.
REQ-012 SHALL have port done_o, output, 1, one-cycle strobe at normal run completion.
REQ-013 SHALL have port pulse_cnt_o, output, 8, pulses emitted in current or last run.
REQ-014 SHALL have ports arm_i (input, 1, arm strobe) and trig_i (input, 1, asynchronous external trigger) only when GLITCH_EXT_TRIG_EN is defined.

Function
REQ-015 SHALL implement states IDLE, ARMED, DELAY, PULSE, GAP.
REQ-016 SHALL, on start accepted at edge T0, capture delay_i, width_i, num_pulses_i and spacing_i into shadow registers; input changes during a run SHALL NOT affect it.
REQ-017 SHALL accept start_i only in IDLE or ARMED; start_i in DELAY, PULSE or GAP SHALL be ignored.
REQ-018 SHALL assert busy_o from edge T0+1 until the edge at which done_o asserts or an abort takes effect.
REQ-019 SHALL drive glitch_o asserted from edge T0+1+delay for exactly width cycles; delay = 0 gives 1-cycle latency.
REQ-020 SHALL hold glitch_o deasserted between pulses for max(spacing, 1) cycles.
REQ-021 SHALL emit exactly num_pulses pulses, then on the edge glitch_o deasserts after the last pulse assert done_o for one cycle, deassert busy_o and enter IDLE.
REQ-022 SHALL treat num_pulses = 0 or width = 0 as a zero-pulse run: glitch_o never asserts, done_o asserts at edge T0+1+delay.
REQ-023 SHALL clear pulse_cnt_o at T0+1, increment it on each pulse's first asserted cycle, and hold it after the run; wrap is impossible (max 255).
REQ-024 SHALL use full-width down-counters; delay 65535 and spacing 65535 SHALL be exact with no wrap or truncation.
REQ-025 SHALL, on abort_i high in any state, deassert glitch_o and busy_o at the next edge and enter IDLE without asserting done_o; pulse_cnt_o holds.
REQ-026 SHALL give abort_i priority over start_i and arm_i in the same cycle.

Reset
REQ-027 SHALL on rst enter IDLE, glitch_o = idle level (0 if GLITCH_ACTIVE_HIGH = 1, else 1), busy_o = 0, done_o = 0, pulse_cnt_o = 0, shadow registers and counters 0, synchronizer flops 0.
REQ-028 SHALL abandon a run mid-pulse when rst asserts, with no done_o.

Configuration
REQ-029 SHALL, with GLITCH_EXT_TRIG_EN defined, add arm_i/trig_i; arm_i in IDLE moves to ARMED; trig_i passes a 2-flop synchronizer plus rising-edge detect; a detected rising edge in ARMED starts a run with T0 = third edge sampling trig_i high; start_i in ARMED also starts; abort_i in ARMED returns to IDLE; trig_i edges outside ARMED are ignored.
REQ-030 SHALL, without GLITCH_EXT_TRIG_EN, omit arm_i, trig_i, the synchronizer and the ARMED state; start_i is the only start source.

Verification
REQ-031 delay=3, width=2, num=3, spacing=4, start at T0 -> glitch_o high at T0+4..5, T0+10..11, T0+16..17; done_o at T0+18; pulse_cnt_o=3.
REQ-032 delay=0, width=1, num=1, spacing=0 -> glitch_o high only at T0+1; done_o at T0+2.
REQ-033 num=0, delay=5 -> glitch_o never asserts; done_o at T0+6; pulse_cnt_o=0.
REQ-034 width=10, num=2, abort_i at the 5th asserted cycle of pulse 1 -> glitch_o low next edge, busy_o low, no done_o, pulse_cnt_o=1; second start_i during the run ignored.
REQ-035 GLITCH_EXT_TRIG_EN: arm_i, then trig_i high at edge E1, delay=2, width=1, num=1 -> glitch_o high at E1+5; trig_i edge without arm -> no run.
REQ-036 Changing delay_i from 3 to 100 mid-run (delay=3, num=2) -> run timing unchanged; rst mid-pulse -> glitch_o idle level next edge, no done_o.
